vga_graph_renderer: RTL and testbench

- Generates 640x480@60 Hz VGA timing from a 25 MHz pixel clock and renders a fixed path graph.
- The graph is 8 node squares joined by 7 edges. Node and edge colouring follows the 8 switch inputs.
- Sits under the board top level, which supplies the divided pixel clock and drives the VGA connector directly.
- Output colour format is RGB 3:3:2.

---
 rtl/vga_graph_renderer.sv | 138 +++++++++++++
 tb/tb_vga_graph_renderer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_graph_renderer.sv
// 640x480@60 VGA timing generator that draws an 8-node path graph whose node and
// edge colours follow the switches, latched once per frame. Outputs are RGB 3:3:2, registered.
`timescale 1ns/1ps
module vga_graph_renderer #(
    parameter int unsigned H_VIS  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_VIS  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sw,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue
);

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned RGB_W   = 8;
    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] H_RIGHT    = CNT_W'(H_VIS - 1);
    localparam logic [CNT_W-1:0] V_BOTTOM   = CNT_W'(V_VIS - 1);
    localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_VIS + V_FP + V_SYNC - 1);

    // Graph geometry: nodes every 64 px from x=64 (32 wide), edges fill the gaps.
    localparam logic [CNT_W-1:0] NODE_X0 = CNT_W'(64);
    localparam logic [CNT_W-1:0] NODE_X1 = CNT_W'(543);
    localparam logic [CNT_W-1:0] NODE_Y0 = CNT_W'(224);
    localparam logic [CNT_W-1:0] NODE_Y1 = CNT_W'(255);
    localparam logic [CNT_W-1:0] EDGE_X0 = CNT_W'(96);
    localparam logic [CNT_W-1:0] EDGE_X1 = CNT_W'(511);
    localparam logic [CNT_W-1:0] EDGE_Y0 = CNT_W'(238);
    localparam logic [CNT_W-1:0] EDGE_Y1 = CNT_W'(241);

    localparam logic [RGB_W-1:0] COL_BLACK  = 8'h00;
    localparam logic [RGB_W-1:0] COL_WHITE  = 8'hFF;
    localparam logic [RGB_W-1:0] COL_GREEN  = 8'h1C;
    localparam logic [RGB_W-1:0] COL_GREY   = 8'h49;
    localparam logic [RGB_W-1:0] COL_YELLOW = 8'hFC;
    localparam logic [RGB_W-1:0] COL_BLUE   = 8'h03;

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic [7:0]       sw_frame_q, sw_frame_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;

    logic [CNT_W-1:0] x_node, x_edge;
    logic [2:0]       node_idx, edge_idx, edge_nxt;
    logic             in_node, in_edge, line_end, frame_end, border;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            sw_frame_q <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            rgb_q      <= '0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            sw_frame_q <= sw_frame_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            rgb_q      <= rgb_d;
        end
    end

    // Counters, once-per-frame switch latch, and the pixel colour for the current position.
    always_comb begin
        h_cnt_d    = h_cnt_q + CNT_W'(1);
        v_cnt_d    = v_cnt_q;
        sw_frame_d = sw_frame_q;
        rgb_d      = COL_BLACK;

        line_end  = (h_cnt_q == H_LAST);
        frame_end = line_end && (v_cnt_q == V_LAST);

        if (line_end) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
        end
        if (frame_end) begin
            sw_frame_d = sw;
        end

        hsync_d = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
        vsync_d = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));

        // Offset within the 64 px node/edge pitch: bit 5 clear means inside the 32 px shape.
        x_node   = h_cnt_q - NODE_X0;
        x_edge   = h_cnt_q - EDGE_X0;
        node_idx = 3'(x_node >> 6);
        edge_idx = 3'(x_edge >> 6);
        edge_nxt = edge_idx + 3'd1;

        in_node = (h_cnt_q >= NODE_X0) && (h_cnt_q <= NODE_X1) && !x_node[5]
               && (v_cnt_q >= NODE_Y0) && (v_cnt_q <= NODE_Y1);
        in_edge = (h_cnt_q >= EDGE_X0) && (h_cnt_q <= EDGE_X1) && !x_edge[5]
               && (v_cnt_q >= EDGE_Y0) && (v_cnt_q <= EDGE_Y1);
        border  = (h_cnt_q == '0) || (h_cnt_q == H_RIGHT)
               || (v_cnt_q == '0) || (v_cnt_q == V_BOTTOM);

        if ((h_cnt_q >= H_VIS_END) || (v_cnt_q >= V_VIS_END)) begin
            rgb_d = COL_BLACK;
        end else if (border) begin
            rgb_d = COL_WHITE;
        end else if (in_node) begin
            rgb_d = sw_frame_q[node_idx] ? COL_GREEN : COL_GREY;
        end else if (in_edge) begin
            rgb_d = (sw_frame_q[edge_idx] && sw_frame_q[edge_nxt]) ? COL_YELLOW : COL_BLUE;
        end
    end

    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign red   = rgb_q[7:5];
    assign green = rgb_q[4:2];
    assign blue  = rgb_q[1:0];

endmodule

// File: tb/tb_vga_graph_renderer.sv
// Bench for vga_graph_renderer: fixed pixel table, sync-shape measurements, random
// sampling against a coordinate-level picture model, and asynchronous reset checks.
`timescale 1ns/1ps
module tb_vga_graph_renderer;

    localparam int LINE  = 800;
    localparam int FRAME = 420000;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sw;
    logic       hsync, vsync;
    logic [2:0] red, green;
    logic [1:0] blue;

    always #20 clk = ~clk;

    vga_graph_renderer dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw),
        .hsync (hsync),
        .vsync (vsync),
        .red   (red),
        .green (green),
        .blue  (blue)
    );

    typedef struct {
        int         frame;
        int         h;
        int         v;
        logic [9:0] exp;     // {hsync, vsync, r3 g3 b2}
        logic       set_sw;
        logic [7:0] sw_val;
    } vec_t;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    int         pix;          // pixel index computed by the next edge
    logic [7:0] swf;          // switch value the model believes is latched for this frame
    int         last_h, last_v;
    logic [9:0] last_exp;

    int   hs_low_line0, first_hs_low;
    int   vs_low [2];
    int   vs_fall [2];
    logic vs_prev;

    // Picture described directly from the rules: sync windows, border, then shapes by scan.
    function automatic logic [9:0] model(int h, int v, logic [7:0] s);
        logic       hs, vs, hit;
        logic [7:0] rgb;
        hs  = !(h >= 656 && h <= 751);
        vs  = !(v >= 490 && v <= 491);
        rgb = 8'h00;
        hit = 1'b0;
        if (h < 640 && v < 480) begin
            if (h == 0 || h == 639 || v == 0 || v == 479) begin
                rgb = 8'hFF;
            end else begin
                for (int i = 0; i < 8; i++)
                    if (!hit && h >= 64 + 64*i && h <= 95 + 64*i && v >= 224 && v <= 255) begin
                        hit = 1'b1;
                        rgb = s[i] ? 8'h1C : 8'h49;
                    end
                for (int i = 0; i < 7; i++)
                    if (!hit && h >= 96 + 64*i && h <= 127 + 64*i && v >= 238 && v <= 241) begin
                        hit = 1'b1;
                        rgb = (s[i] && s[i+1]) ? 8'hFC : 8'h03;
                    end
            end
        end
        return {hs, vs, rgb};
    endfunction

    function automatic logic [9:0] dut_out();
        return {hsync, vsync, red, green, blue};
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic meas_init();
        pix          = 0;
        swf          = 8'h00;
        hs_low_line0 = 0;
        first_hs_low = -1;
        vs_low[0]    = 0;
        vs_low[1]    = 0;
        vs_fall[0]   = -1;
        vs_fall[1]   = -1;
        vs_prev      = 1'b1;
    endtask

    // One clock: the edge registers pixel 'pix' and, at frame end, latches sw.
    task automatic step();
        logic [7:0] sw_edge;
        int         f;
        sw_edge = sw;
        @(posedge clk);
        #1;
        last_h   = pix % LINE;
        last_v   = (pix / LINE) % 525;
        f        = pix / FRAME;
        last_exp = model(last_h, last_v, swf);
        if (last_h == 799 && last_v == 524) swf = sw_edge;
        pix++;
        if (pix <= LINE && hsync === 1'b0) begin
            hs_low_line0++;
            if (first_hs_low < 0) first_hs_low = pix;
        end
        if (f < 2) begin
            if (vsync === 1'b0) vs_low[f]++;
            if (vs_prev === 1'b1 && vsync === 1'b0) vs_fall[f] = pix;
        end
        vs_prev = vsync;
        if ($urandom_range(0, 511) == 0)
            check($sformatf("model(%0d,%0d)", last_h, last_v), dut_out(), last_exp);
    endtask

    vec_t tbl [20];

    initial begin
        int t;
        tbl[0]  = '{0,   0,   0, 10'h3FF, 1'b0, 8'h00};
        tbl[1]  = '{0, 300, 100, 10'h300, 1'b1, 8'hFF};
        tbl[2]  = '{0,  80, 240, 10'h349, 1'b0, 8'h00};
        tbl[3]  = '{0, 110, 240, 10'h303, 1'b0, 8'h00};
        tbl[4]  = '{0, 400, 240, 10'h349, 1'b0, 8'h00};
        tbl[5]  = '{0, 700, 240, 10'h100, 1'b0, 8'h00};
        tbl[6]  = '{0,  80, 300, 10'h300, 1'b1, 8'h03};
        tbl[7]  = '{0,  80, 479, 10'h3FF, 1'b0, 8'h00};
        tbl[8]  = '{0,  80, 500, 10'h300, 1'b0, 8'h00};
        tbl[9]  = '{1,   0,   0, 10'h3FF, 1'b0, 8'h00};
        tbl[10] = '{1,  95, 224, 10'h31C, 1'b0, 8'h00};
        tbl[11] = '{1,  96, 224, 10'h300, 1'b0, 8'h00};
        tbl[12] = '{1, 110, 239, 10'h3FC, 1'b0, 8'h00};
        tbl[13] = '{1, 174, 239, 10'h303, 1'b0, 8'h00};
        tbl[14] = '{1,  80, 240, 10'h31C, 1'b0, 8'h00};
        tbl[15] = '{1, 144, 240, 10'h31C, 1'b0, 8'h00};
        tbl[16] = '{1, 208, 240, 10'h349, 1'b0, 8'h00};
        tbl[17] = '{1, 639, 240, 10'h3FF, 1'b0, 8'h00};
        tbl[18] = '{1, 640, 240, 10'h300, 1'b0, 8'h00};
        tbl[19] = '{1, 127, 241, 10'h3FC, 1'b0, 8'h00};

        reset = 1'b0;
        sw    = 8'h00;
        meas_init();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", dut_out(), 10'h300);

        // First pixel after release, then an asynchronous reset between edges.
        reset = 1'b1;
        step();
        check("first_pixel", dut_out(), 10'h3FF);
        #3 reset = 1'b0;
        #1 check("async_reset_white", dut_out(), 10'h300);
        repeat (2) @(posedge clk);
        #1 check("held_in_reset", dut_out(), 10'h300);
        reset = 1'b1;
        meas_init();

        for (int i = 0; i < 20; i++) begin
            t = tbl[i].frame * FRAME + tbl[i].v * LINE + tbl[i].h;
            while (pix <= t) step();
            check($sformatf("pixel f%0d(%0d,%0d)", tbl[i].frame, tbl[i].h, tbl[i].v),
                  dut_out(), tbl[i].exp);
            if (tbl[i].set_sw) sw = tbl[i].sw_val;
        end

        // Mid-frame switch noise must not reach the picture of the current frame.
        t = FRAME + 492 * LINE;
        while (pix <= t) begin
            if (pix % LINE == 0) sw = 8'($urandom);
            step();
        end
        check_int("hsync_low_len", hs_low_line0, 96);
        check_int("hsync_first_low", first_hs_low, 657);
        check_int("vsync_low_f0", vs_low[0], 1600);
        check_int("vsync_low_f1", vs_low[1], 1600);
        check_int("vsync_first_fall", vs_fall[0], 392001);
        check_int("frame_period", vs_fall[1] - vs_fall[0], FRAME);

        t = FRAME + 492 * LINE + 700;
        while (pix <= t) step();
        check("pre_reset_hsync", dut_out(), last_exp);
        check("pre_reset_const", dut_out(), 10'h100);
        #5 reset = 1'b0;
        #1 check("async_reset_hsync", dut_out(), 10'h300);
        repeat (2) @(posedge clk);
        #1 check("async_reset_hold", dut_out(), 10'h300);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
